// File: rtl/pipeline_arbiter.sv
// Round-robin issue of N requesters onto one in-order worker. An in-order tag
// FIFO remembers who issued each transaction so the result can be steered back.
module pipeline_arbiter #(
  parameter int N         = 4,
  parameter int W         = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N*W-1:0]                 req_data,
  input  logic [N-1:0]                   req_valid,
  output logic [N-1:0]                   req_ready,
  output logic [W-1:0]                   rsp_data,
  output logic [N-1:0]                   rsp_valid,
  input  logic [N-1:0]                   rsp_ready,
  output logic [W-1:0]                   wk_us_data,
  output logic                           wk_us_valid,
  input  logic                           wk_us_ready,
  input  logic [W-1:0]                   wk_ds_data,
  input  logic                           wk_ds_valid,
  output logic                           wk_ds_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic                           err_orphan
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_lockIdx;
  logic          r_lock;
  logic [IW-1:0] r_tags [TAG_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_errOrphan;

  logic [IW-1:0] w_grant;
  logic [IW-1:0] w_head;
  logic          w_tagFull;
  logic          w_tagEmpty;
  logic          w_issueFire;
  logic          w_popFire;

  assign w_tagFull  = (r_count == CW'(TAG_DEPTH));
  assign w_tagEmpty = (r_count == '0);
  assign w_head     = r_tags[r_rdPtr];

  // Descending scan so the candidate closest to the pointer is the one that sticks.
  always_comb begin
    w_grant = r_ptr;
    if (r_lock) begin
      w_grant = r_lockIdx;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[(int'(r_ptr) + k) % N]) begin
          w_grant = IW'((int'(r_ptr) + k) % N);
        end
      end
    end
  end

  assign wk_us_valid = !reset && req_valid[w_grant] && !w_tagFull;
  assign wk_us_data  = req_data[int'(w_grant)*W +: W];
  assign w_issueFire = wk_us_valid && wk_us_ready;

  assign wk_ds_ready = !reset && !w_tagEmpty && rsp_ready[w_head];
  assign w_popFire   = wk_ds_valid && wk_ds_ready;
  assign rsp_data    = wk_ds_data;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (w_issueFire) begin
      req_ready[w_grant] = 1'b1;
    end
    if (!reset && wk_ds_valid && !w_tagEmpty) begin
      rsp_valid[w_head] = 1'b1;
    end
  end

  // A stalled offer locks the grant so the worker sees a stable request until it accepts.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr       <= '0;
      r_lock      <= 1'b0;
      r_lockIdx   <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_errOrphan <= 1'b0;
    end else begin
      if (w_issueFire) begin
        r_tags[r_wrPtr] <= w_grant;
        r_wrPtr         <= r_wrPtr + PW'(1);
        r_ptr           <= (w_grant == IW'(N - 1)) ? '0 : w_grant + IW'(1);
        r_lock          <= 1'b0;
      end else if (wk_us_valid) begin
        r_lock    <= 1'b1;
        r_lockIdx <= w_grant;
      end
      if (w_popFire) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_issueFire, w_popFire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wk_ds_valid && w_tagEmpty) begin
        r_errOrphan <= 1'b1;
      end
    end
  end

  assign outstanding = r_count;
  assign err_orphan  = r_errOrphan;

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Randomized bench for pipeline_arbiter: the bench plays requesters and an in-order
// worker; a transaction-level model predicts grants, steering and counts.
module tb_pipeline_arbiter;

  localparam int N      = 4;
  localparam int W      = 16;
  localparam int TD     = 4;
  localparam int WK_CAP = 6;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   rsp_data;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   wk_us_data;
  logic           wk_us_valid;
  logic           wk_us_ready;
  logic [W-1:0]   wk_ds_data;
  logic           wk_ds_valid;
  logic           wk_ds_ready;
  logic [2:0]     outstanding;
  logic           err_orphan;

  pipeline_arbiter #(.N(N), .W(W), .TAG_DEPTH(TD)) dut (
    .clock(clock), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .wk_us_data(wk_us_data), .wk_us_valid(wk_us_valid), .wk_us_ready(wk_us_ready),
    .wk_ds_data(wk_ds_data), .wk_ds_valid(wk_ds_valid), .wk_ds_ready(wk_ds_ready),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           idx;
    logic [W-1:0] res;
  } expT;

  typedef struct {
    logic [W-1:0] res;
    int           rdy;
  } wkT;

  expT expQ[$];
  wkT  wkQ[$];

  int testsRun;
  int testsFailed;
  int cycleCount;

  // Stimulus knobs, changed by the main sequence away from the driver's edge.
  logic [N-1:0] reqMask;
  int           pRaise;
  int           pRspReady;
  int           pUsReady;
  int           latMin;
  int           latMax;
  logic         dsEnable;
  logic         injectOrphan;

  // Handshakes observed by the monitor, consumed by the driver after the edge.
  logic         lastUsFire;
  logic [W-1:0] lastUsData;
  logic         lastDsFire;
  logic [N-1:0] lastReqReady;

  int           mPtr;
  logic         mLocked;
  int           mLockIdx;
  logic         mOrphan;
  logic         prevStall;
  logic [N-1:0] prevRspValid;
  logic [W-1:0] prevRspData;

  function automatic logic [W-1:0] workerFn(input logic [W-1:0] x);
    return (x * 16'd3) ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic applyStimulus();
    cycleCount++;
    if (reset) begin
      wkQ.delete();
      req_valid   = '0;
      rsp_ready   = '0;
      wk_us_ready = 1'b0;
      wk_ds_valid = 1'b0;
      return;
    end
    if (lastDsFire && wkQ.size() > 0) wkQ.pop_front();
    if (lastUsFire) wkQ.push_back('{workerFn(lastUsData), cycleCount + int'($urandom_range(latMax, latMin))});
    for (int i = 0; i < N; i++) begin
      if (lastReqReady[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && reqMask[i] && int'($urandom_range(99)) < pRaise) begin
        req_valid[i]        = 1'b1;
        req_data[i*W +: W]  = W'($urandom);
      end
      rsp_ready[i] = int'($urandom_range(99)) < pRspReady;
    end
    wk_us_ready = (wkQ.size() < WK_CAP) && (int'($urandom_range(99)) < pUsReady);
    if (!(wk_ds_valid && !lastDsFire && wkQ.size() > 0)) begin
      wk_ds_valid = dsEnable && wkQ.size() > 0 && cycleCount >= wkQ[0].rdy;
    end
    if (injectOrphan) wk_ds_valid = 1'b1;
    wk_ds_data = (wkQ.size() > 0) ? wkQ[0].res : W'($urandom);
  endtask

  initial begin
    req_valid   = '0;
    req_data    = '0;
    rsp_ready   = '0;
    wk_us_ready = 1'b0;
    wk_ds_valid = 1'b0;
    wk_ds_data  = '0;
    forever begin
      @(posedge clock);
      #1;
      applyStimulus();
    end
  end

  // Monitor: compare against the model's current view, then advance the model.
  always @(negedge clock) begin
    int g;
    logic expUsValid;
    logic [N-1:0] expRspValid;
    logic expDsReady;
    if (reset) begin
      checkOutput("reset_req_ready", int'(req_ready), 0);
      checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
      checkOutput("reset_wk_us_valid", int'(wk_us_valid), 0);
      checkOutput("reset_wk_ds_ready", int'(wk_ds_ready), 0);
      expQ.delete();
      mPtr = 0; mLocked = 1'b0; mLockIdx = 0; mOrphan = 1'b0; prevStall = 1'b0;
    end else begin
      checkOutput("outstanding", int'(outstanding), expQ.size());
      checkOutput("err_orphan", int'(err_orphan), int'(mOrphan));
      if (prevStall) begin
        checkOutput("stall_rsp_valid", int'(rsp_valid), int'(prevRspValid));
        checkOutput("stall_rsp_data", int'(rsp_data), int'(prevRspData));
      end
      g = mPtr;
      if (mLocked) g = mLockIdx;
      else for (int k = 0; k < N; k++) begin
        if (req_valid[(mPtr + k) % N]) begin
          g = (mPtr + k) % N;
          break;
        end
      end
      expUsValid = req_valid[g] && (expQ.size() < TD);
      checkOutput("wk_us_valid", int'(wk_us_valid), int'(expUsValid));
      if (expUsValid && wk_us_ready) begin
        checkOutput("grant", int'(req_ready), 1 << g);
        checkOutput("wk_us_data", int'(wk_us_data), int'(req_data[g*W +: W]));
      end else begin
        checkOutput("req_ready_idle", int'(req_ready), 0);
      end
      expRspValid = (wk_ds_valid && expQ.size() > 0) ? N'(1 << expQ[0].idx) : '0;
      expDsReady  = (expQ.size() > 0) && rsp_ready[expQ[0].idx];
      checkOutput("rsp_valid", int'(rsp_valid), int'(expRspValid));
      checkOutput("wk_ds_ready", int'(wk_ds_ready), int'(expDsReady));
      prevStall    = wk_ds_valid && (expQ.size() > 0) && !expDsReady;
      prevRspValid = rsp_valid;
      prevRspData  = rsp_data;
      if (wk_ds_valid && expQ.size() == 0) mOrphan = 1'b1;
      if (wk_ds_valid && expDsReady) begin
        checkOutput("rsp_data", int'(rsp_data), int'(expQ[0].res));
        void'(expQ.pop_front());
      end
      if (expUsValid && wk_us_ready) begin
        expQ.push_back('{g, workerFn(req_data[g*W +: W])});
        mPtr    = (g + 1) % N;
        mLocked = 1'b0;
      end else if (expUsValid) begin
        mLocked  = 1'b1;
        mLockIdx = g;
      end
    end
    lastUsFire   = wk_us_valid && wk_us_ready;
    lastUsData   = wk_us_data;
    lastDsFire   = wk_ds_valid && wk_ds_ready;
    lastReqReady = req_ready;
  end

  task automatic runCycles(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic drain();
    int budget;
    reqMask = '0; pRspReady = 100; pUsReady = 100; dsEnable = 1'b1;
    budget = 0;
    while ((req_valid != '0 || outstanding != 0) && budget < 500) begin
      @(negedge clock);
      budget++;
    end
    #2;
    if (budget >= 500) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL drain_timeout: outstanding=%0d, required 0", outstanding);
    end
  endtask

  initial begin
    testsRun = 0; testsFailed = 0; cycleCount = 0;
    reqMask = '0; pRaise = 0; pRspReady = 100; pUsReady = 100;
    latMin = 1; latMax = 4; dsEnable = 1'b1; injectOrphan = 1'b0;
    lastUsFire = 1'b0; lastDsFire = 1'b0; lastReqReady = '0; lastUsData = '0;
    mPtr = 0; mLocked = 1'b0; mLockIdx = 0; mOrphan = 1'b0; prevStall = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_outstanding", int'(outstanding), 0);
    checkOutput("post_reset_orphan", int'(err_orphan), 0);

    // Single requester streaming back to back.
    #2 reqMask = 4'b0100; pRaise = 100;
    runCycles(40);
    drain();

    // All requesters always valid: rotation fairness.
    reqMask = 4'hF; pRaise = 100;
    runCycles(60);
    drain();

    // Worker withholds results until the tag FIFO fills.
    reqMask = 4'hF; pRaise = 100; dsEnable = 1'b0;
    runCycles(12);
    checkOutput("full_outstanding", int'(outstanding), TD);
    checkOutput("full_blocks_issue", int'(wk_us_valid), 0);
    dsEnable = 1'b1;
    runCycles(30);
    drain();

    // Response back-pressure and upstream stalls exercising the lock.
    reqMask = 4'hF; pRaise = 50; pRspReady = 30; pUsReady = 40; latMax = 6;
    runCycles(400);
    repeat (6) begin
      reqMask   = N'($urandom);
      pRaise    = int'($urandom_range(100, 10));
      pRspReady = int'($urandom_range(100, 20));
      pUsReady  = int'($urandom_range(100, 20));
      runCycles(300);
    end
    drain();

    // Reset with transactions in flight, then an orphan result.
    reqMask = 4'hF; pRaise = 100; dsEnable = 1'b0;
    begin
      int budget = 0;
      while (outstanding < 3 && budget < 100) begin
        @(negedge clock);
        budget++;
      end
      if (budget >= 100) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL fill_timeout: outstanding=%0d, required >=3", outstanding);
      end
    end
    #2 reqMask = '0;
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset_outstanding", int'(outstanding), 0);
    #2 injectOrphan = 1'b1;
    @(negedge clock);
    #2 injectOrphan = 1'b0;
    @(negedge clock);
    checkOutput("orphan_set", int'(err_orphan), 1);
    checkOutput("orphan_no_rsp", int'(rsp_valid), 0);
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    checkOutput("orphan_cleared", int'(err_orphan), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pipeline_arbiter.md
Name: pipeline_arbiter

Overview:
Shares one iterative ready/valid worker (16-bit data, variable latency, in-order completion) between N requesters. Round-robin arbitration on the issue side. An in-order tag FIFO steers each worker result back to the requester that issued it. Sits between N client streams and a single worker instance; worker handshake is standard us/ds ready/valid.

Parameters:
N, 4, number of requesters (2..8)
W, 16, data width (matches worker)
TAG_DEPTH, 4, max outstanding transactions tracked (power of 2, >=2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
req_data  in  N*W  requester i payload at [i*W +: W]
req_valid  in  N  requester i valid
req_ready  out  N  requester i accepted this cycle
rsp_data  out  W  result payload, broadcast to all requesters
rsp_valid  out  N  result valid, one-hot to owning requester
rsp_ready  in  N  requester i can take result
wk_us_data  out  W  to worker us_data
wk_us_valid  out  1  to worker us_valid
wk_us_ready  in  1  from worker us_ready
wk_ds_data  in  W  from worker ds_data
wk_ds_valid  in  1  from worker ds_valid
wk_ds_ready  out  1  to worker ds_ready
outstanding  out  $clog2(TAG_DEPTH+1)  tags currently in FIFO
err_orphan  out  1  sticky: worker produced result with tag FIFO empty

Behaviour:
- Reset: rr pointer=0, lock=0, tag FIFO empty, outstanding=0, err_orphan=0. All req_ready/rsp_valid/wk_us_valid/wk_ds_ready are 0 while reset is high. The worker shares the same reset; reset mid-operation drops all in-flight tags with no responses.
- Issue arbitration (combinational from state):
  - Grant = first i with req_valid[i], scanning from pointer upward mod N.
  - If lock=1, grant = locked index instead.
- wk_us_valid = req_valid[grant] && !tag_full. wk_us_data = req_data[grant].
- req_ready[i] = (i==grant) && wk_us_valid && wk_us_ready. All other bits are 0.
- Issue fire = wk_us_valid && wk_us_ready. On fire: push grant index into tag FIFO; pointer <= grant+1 mod N; lock <= 0.
- Lock: if wk_us_valid && !wk_us_ready, set lock=1 and hold the grant index. The offered request cannot change until accepted. Requesters must hold valid/data until ready (protocol rule; not checked).
- Full: tag_full blocks issue even if a pop occurs in the same cycle (no full-bypass). Lock is not set while full.
- Response steering: head = tag FIFO head.
  - rsp_valid[i] = wk_ds_valid && !tag_empty && (head==i).
  - rsp_data = wk_ds_data, driven unconditionally.
  - wk_ds_ready = !tag_empty && rsp_ready[head].
  - Pop when wk_ds_valid && wk_ds_ready.
- Simultaneous push and pop: both occur; outstanding unchanged. The FIFO pointers wrap mod TAG_DEPTH.
- Orphan: wk_ds_valid && tag_empty sets err_orphan (sticky until reset). wk_ds_ready stays 0.
- Latency: zero added cycles on either path. Issue and result steering are combinational; state updates on the following edge.
- Back-pressure: a stalled rsp_ready[head] holds the worker. The worker then deasserts us_ready, which naturally blocks new issue.

Test Plan:
1. Single requester: req 2 sends 0x0001, 0x0002 back to back, all rsp_ready=1 -> two wk_us fires with req_ready[2] pulses; results arrive only on rsp_valid[2] in issue order; outstanding returns to 0.
2. Round-robin fairness: all 4 req_valid held high, worker always ready -> grant order 0,1,2,3,0,1 over 6 fires; each requester receives exactly its own results in order.
3. Lock: pointer=0, only req 2 valid, wk_us_ready=0 for 3 cycles, req 1 raises valid in cycle 2 -> wk_us_data stays req 2 data; req_ready[2] fires when ready rises; next grant goes to req 3 if valid, else wraps to req 1.
4. Full: worker model with TAG_DEPTH=4 accepts 4 without results -> outstanding=4 and wk_us_valid=0 despite pending req. Release one result with pop -> issue resumes the next cycle, not the same cycle.
5. Response back-pressure: head tag=1, rsp_ready[1]=0 for 5 cycles -> wk_ds_ready=0 and rsp_valid[1]=1 held stable with unchanged rsp_data. Other rsp_valid bits stay 0 throughout.
6. Reset mid-flight with outstanding=3, then inject wk_ds_valid with empty FIFO -> after reset outstanding=0 and pointer=0; the orphan sets err_orphan=1 with no rsp_valid; err_orphan clears on the next reset.
